// File: rtl/im_loader.sv
// im_loader: boot-time program loader for the single-cycle core.
//
// Accepts a byte stream (valid/ready) framed as a 16-bit little-endian word
// count N followed by 4*N data bytes. Bytes are packed into little-endian
// 32-bit words and written to consecutive instruction-memory word addresses.
// The core is held in reset until the last word is written.
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   byte_in       - stream data byte
//   byte_valid    - byte_in valid this cycle
//   byte_ready    - loader accepts a byte this cycle
//   im_we         - instruction-memory write strobe (one cycle per word)
//   im_waddr      - instruction-memory word address
//   im_wdata      - instruction word
//   cpu_rst       - core reset, high until the image is fully loaded
//   done          - image loaded, core running (sticky)
//   err           - load aborted: length over DEPTH or idle timeout (sticky)
module im_loader #(
    parameter int ADDR_W  = 10,
    parameter int DEPTH   = 1024,
    parameter int TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_waddr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_LEN0, S_LEN1, S_DATA, S_WRITE, S_DONE, S_ERR
    } state_t;

    state_t            state, state_nx;
    logic [15:0]       n_words;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_idx;
    logic [23:0]       lo_bytes;   // bytes 0..2 of the word being assembled
    logic [TW-1:0]     idle_cnt;

    logic        xfer;
    logic        idle_hit;
    logic        last_word;
    logic [15:0] n_full;

    assign xfer      = byte_valid && byte_ready;
    assign n_full    = {byte_in, n_words[7:0]};
    assign last_word = (32'(word_idx) == (32'(n_words) - 32'd1));

    // The idle cycle that brings the counter up to TIMEOUT aborts the load.
    assign idle_hit = (TIMEOUT > 0) && !xfer &&
                      ((state == S_LEN1) || (state == S_DATA)) &&
                      (idle_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        state_nx = state;
        case (state)
            S_LEN0:  if (xfer) state_nx = S_LEN1;
            S_LEN1: begin
                if (xfer) begin
                    if (n_full == 16'd0)
                        state_nx = S_DONE;
                    else if (32'(n_full) > 32'(DEPTH))
                        state_nx = S_ERR;
                    else
                        state_nx = S_DATA;
                end else if (idle_hit) begin
                    state_nx = S_ERR;
                end
            end
            S_DATA: begin
                if (xfer && (byte_idx == 2'd3))
                    state_nx = S_WRITE;
                else if (idle_hit)
                    state_nx = S_ERR;
            end
            S_WRITE: state_nx = last_word ? S_DONE : S_DATA;
            S_DONE:  state_nx = S_DONE;
            S_ERR:   state_nx = S_ERR;
            default: state_nx = S_LEN0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_LEN0;
            byte_ready <= 1'b0;
            im_we      <= 1'b0;
            im_waddr   <= '0;
            im_wdata   <= '0;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            n_words    <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            lo_bytes   <= '0;
            idle_cnt   <= '0;
        end else begin
            state <= state_nx;
            // Outputs are decoded from the next state so they line up with
            // the state they describe.
            byte_ready <= (state_nx == S_LEN0) || (state_nx == S_LEN1) ||
                          (state_nx == S_DATA);
            im_we      <= (state_nx == S_WRITE);
            cpu_rst    <= (state_nx != S_DONE);
            done       <= (state_nx == S_DONE);
            err        <= (state_nx == S_ERR);

            if ((state == S_LEN0) && xfer)
                n_words[7:0] <= byte_in;

            if ((state == S_LEN1) && xfer) begin
                n_words[15:8] <= byte_in;
                word_idx      <= '0;
                byte_idx      <= '0;
            end

            if ((state == S_DATA) && xfer) begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0: lo_bytes[7:0]   <= byte_in;
                    2'd1: lo_bytes[15:8]  <= byte_in;
                    2'd2: lo_bytes[23:16] <= byte_in;
                    default: begin
                        im_wdata <= {byte_in, lo_bytes};
                        im_waddr <= word_idx;
                    end
                endcase
            end

            if ((state == S_WRITE) && !last_word)
                word_idx <= word_idx + 1'b1;

            if (xfer || !((state == S_LEN1) || (state == S_DATA)))
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_im_loader.sv
module tb_im_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        im_we;
    logic [9:0]  im_waddr;
    logic [31:0] im_wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;

    im_loader #(.ADDR_W(10), .DEPTH(1024), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .im_we(im_we), .im_waddr(im_waddr),
        .im_wdata(im_wdata), .cpu_rst(cpu_rst), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  tx_q[$];
    int unsigned exp_addr[$];
    logic [31:0] exp_data[$];
    bit          exp_done, exp_err;
    int unsigned obs_addr[$];
    logic [31:0] obs_data[$];
    int          obs_cyc[$];
    int          ready_viol;

    // Reference: decode the frame straight from its definition.
    function automatic void build_model();
        int n;
        exp_addr.delete(); exp_data.delete();
        exp_done = 0; exp_err = 0;
        n = int'(tx_q[0]) | (int'(tx_q[1]) << 8);
        if (n == 0) exp_done = 1;
        else if (n > 1024) exp_err = 1;
        else begin
            for (int w = 0; w < n; w++) begin
                exp_addr.push_back(w);
                exp_data.push_back({tx_q[2+4*w+3], tx_q[2+4*w+2],
                                    tx_q[2+4*w+1], tx_q[2+4*w]});
            end
            exp_done = 1;
        end
    endfunction

    task automatic do_reset();
        rst = 1'b1; byte_valid = 1'b0; byte_in = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // mode 0: valid always high; 1: toggle, held high in WRITE; 2: random gaps
    task automatic send(input int mode);
        int idx = 0, guard = 0, gaps = 0;
        logic rdy;
        obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
        ready_viol = 0;
        while (idx < tx_q.size()) begin
            case (mode)
                0: byte_valid = 1'b1;
                1: byte_valid = (guard % 2 == 0) || im_we;
                default: begin
                    byte_valid = (gaps >= 3) || ($urandom_range(0, 3) != 0);
                    gaps = byte_valid ? 0 : gaps + 1;
                end
            endcase
            byte_in = byte_valid ? tx_q[idx] : 8'($urandom);
            rdy = byte_ready;
            @(posedge clk); #1;
            if (byte_valid && rdy) idx++;
            if (im_we) begin
                obs_addr.push_back(im_waddr);
                obs_data.push_back(im_wdata);
                obs_cyc.push_back(cyc);
            end
            if (!done && !err && (byte_ready !== !im_we)) ready_viol++;
            guard++;
            if (guard > 20000) begin
                errors++; checks++;
                $display("FAIL send_timeout: sent %0d of %0d bytes", idx, tx_q.size());
                break;
            end
        end
        byte_valid = 1'b0;
        @(posedge clk); #1;
        if (im_we) begin
            obs_addr.push_back(im_waddr);
            obs_data.push_back(im_wdata);
            obs_cyc.push_back(cyc);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({byte_ready, im_we, im_waddr, im_wdata, cpu_rst, done, err} !==
            {1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b we=%b a=%0d d=%h crst=%b done=%b err=%b want 0 0 0 0 1 0 0",
                     byte_ready, im_we, im_waddr, im_wdata, cpu_rst, done, err);
        end
        @(posedge clk); #1;
        checks++;
        if (byte_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", byte_ready);
        end
    endtask

    task automatic test_two_words(input int mode);
        do_reset();
        tx_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h20, 8'h08, 8'h00, 8'h00, 8'h00};
        build_model();
        send(mode);
        checks++;
        if (obs_addr.size() !== 2) begin
            errors++; $display("FAIL two_words_count(mode %0d): got %0d want 2", mode, obs_addr.size());
        end else begin
            checks++;
            if ({obs_addr[0], obs_data[0], obs_addr[1], obs_data[1]} !==
                {32'd0, 32'h20000013, 32'd1, 32'h00000008}) begin
                errors++;
                $display("FAIL two_words_data(mode %0d): got %0d:%h %0d:%h want 0:20000013 1:00000008",
                         mode, obs_addr[0], obs_data[0], obs_addr[1], obs_data[1]);
            end
            if (mode == 0) begin
                checks++;
                if (obs_cyc[1] - obs_cyc[0] !== 5) begin
                    errors++; $display("FAIL two_words_spacing: got %0d want 5", obs_cyc[1] - obs_cyc[0]);
                end
            end
        end
        checks++;
        if ({done, cpu_rst, err} !== {exp_done, 1'b0, exp_err}) begin
            errors++; $display("FAIL two_words_done(mode %0d): got done=%b crst=%b err=%b want 1 0 0",
                               mode, done, cpu_rst, err);
        end
        checks++;
        if (ready_viol !== 0) begin
            errors++; $display("FAIL two_words_ready(mode %0d): got %0d bad cycles want 0", mode, ready_viol);
        end
    endtask

    task automatic test_image(input string name, input int mode);
        build_model();
        send(mode);
        checks++;
        if (obs_addr.size() !== exp_addr.size()) begin
            errors++; $display("FAIL %s_count: got %0d want %0d", name, obs_addr.size(), exp_addr.size());
        end else begin
            for (int i = 0; i < obs_addr.size(); i++) begin
                checks++;
                if ((obs_addr[i] !== exp_addr[i]) || (obs_data[i] !== exp_data[i])) begin
                    errors++; $display("FAIL %s_word%0d: got %0d:%h want %0d:%h", name, i,
                                       obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
                end
            end
        end
        checks++;
        if ({done, err, cpu_rst} !== {exp_done, exp_err, !exp_done}) begin
            errors++; $display("FAIL %s_status: got done=%b err=%b crst=%b want %b %b %b", name,
                               done, err, cpu_rst, exp_done, exp_err, !exp_done);
        end
        checks++;
        if (ready_viol !== 0) begin
            errors++; $display("FAIL %s_ready: got %0d bad cycles want 0", name, ready_viol);
        end
    endtask

    task automatic test_boundaries();
        do_reset();
        tx_q = '{8'h00, 8'h00};
        test_image("n0", 0);
        do_reset();
        tx_q = '{8'h00, 8'h04};
        for (int i = 0; i < 4096; i++) tx_q.push_back(8'($urandom));
        test_image("n1024", 2);
        checks++;
        if ((obs_addr.size() == 0) || (obs_addr[obs_addr.size()-1] !== 1023)) begin
            errors++; $display("FAIL n1024_last_addr: got %0d want 1023",
                               obs_addr.size() == 0 ? -1 : int'(obs_addr[obs_addr.size()-1]));
        end
        do_reset();
        tx_q = '{8'h01, 8'h04};
        test_image("n1025", 0);
    endtask

    task automatic test_timeout();
        logic [7:0] bs[3] = '{8'h01, 8'h00, 8'hAA};
        int we_seen = 0;
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            byte_valid = 1'b1; byte_in = bs[i];
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (im_we) we_seen++;
            checks++;
            if (err !== (k >= 8)) begin
                errors++; $display("FAIL timeout_err_cycle%0d: got %b want %b", k, err, k >= 8);
            end
        end
        checks++;
        if ((we_seen !== 0) || (cpu_rst !== 1'b1)) begin
            errors++; $display("FAIL timeout_side: got we=%0d crst=%b want 0 1", we_seen, cpu_rst);
        end
        do_reset();
        repeat (100) @(posedge clk);
        #1;
        checks++;
        if ({err, byte_ready} !== 2'b01) begin
            errors++; $display("FAIL len0_idle: got err=%b rdy=%b want 0 1", err, byte_ready);
        end
    endtask

    task automatic test_reset_midload();
        do_reset();
        tx_q = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send(0);
        do_reset();
        checks++;
        if ({byte_ready, im_we, im_waddr, im_wdata, cpu_rst, done, err} !==
            {1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midload_reset: got rdy=%b we=%b a=%0d d=%h crst=%b done=%b err=%b want 0 0 0 0 1 0 0",
                     byte_ready, im_we, im_waddr, im_wdata, cpu_rst, done, err);
        end
        tx_q = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        test_image("after_reset", 1);
        checks++;
        if ((obs_data.size() != 1) || (obs_data[0] !== 32'hDEADBEEF)) begin
            errors++; $display("FAIL after_reset_word: got %h want deadbeef",
                               obs_data.size() == 1 ? obs_data[0] : 32'hx);
        end
    endtask

    task automatic test_post_done();
        int bad = 0;
        for (int i = 0; i < 20; i++) begin
            byte_valid = 1'b1; byte_in = 8'($urandom);
            @(posedge clk); #1;
            if ({byte_ready, im_we, done} !== 3'b001) bad++;
        end
        byte_valid = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL post_done: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            int n = $urandom_range(1, 6);
            do_reset();
            tx_q = '{8'(n), 8'h00};
            for (int i = 0; i < 4*n; i++) tx_q.push_back(8'($urandom));
            test_image("random", 2);
        end
    endtask

    initial begin
        rst = 1'b1; byte_valid = 1'b0; byte_in = 8'h00;
        test_reset();
        test_two_words(0);
        test_two_words(1);
        test_boundaries();
        test_timeout();
        test_reset_midload();
        test_post_done();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
